// File: rtl/mp_add_seq.sv
// Sequential 64-bit adder: one 16-bit slice reused over four passes with a rippled carry.
// Define ADDER_SUB_EN to add the sub port (A-B through inverted B and a forced carry-in).
module mp_add_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
`ifdef ADDER_SUB_EN
    input  logic        sub,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] sum,
    output logic        co,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready is high only in IDLE and out_valid only in DONE, so the two never overlap.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [63:0] a_r;
    logic [63:0] b_r;
    logic [1:0]  idx;
    logic        carry;
    logic [15:0] x;
    logic [15:0] y;
    logic [16:0] slice;

    assign dbg_state = state;

    always_comb begin
        x     = a_r[16*idx +: 16];
        y     = b_r[16*idx +: 16];
        slice = {1'b0, x} + {1'b0, y} + {16'b0, carry};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            idx       <= '0;
            carry     <= 1'b0;
            sum       <= '0;
            co        <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r      <= a;
`ifdef ADDER_SUB_EN
                        // Two's complement subtract: invert B, carry-in of 1 replaces cin.
                        b_r      <= sub ? ~b : b;
                        carry    <= sub | cin;
`else
                        b_r      <= b;
                        carry    <= cin;
`endif
                        idx      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    sum[16*idx +: 16] <= slice[15:0];
                    carry             <= slice[16];
                    idx               <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        co        <= slice[16];
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed bench for mp_add_seq: reset, latency, carry ripple, stall, back-to-back, reset abort.
module tb_mp_add_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] sum;
    logic        co;
    logic        busy;
    logic [1:0]  dbg_state;

    int compared;
    int mismatched;

    mp_add_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .co        (co),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one operation, check the 4-edge latency and the result, then retire it.
    task automatic run_op(input string tag, input logic [63:0] av, input logic [63:0] bv,
                          input logic ci, input logic sb,
                          input logic [63:0] es, input logic ec);
        a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        chk({tag, "_busy"}, {63'b0, busy}, 64'd1);
        chk({tag, "_inrdy_run"}, {63'b0, in_ready}, 64'd0);
        for (int i = 1; i < 4; i++) begin
            step();
            chk({tag, "_early_valid"}, {63'b0, out_valid}, 64'd0);
        end
        step();
        chk({tag, "_valid"}, {63'b0, out_valid}, 64'd1);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_co"}, {63'b0, co}, {63'b0, ec});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_retired"}, {63'b0, out_valid}, 64'd0);
        chk({tag, "_inrdy_idle"}, {63'b0, in_ready}, 64'd1);
    endtask

    initial begin
        compared = 0; mismatched = 0;
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        a = 64'hDEAD; b = 64'hBEEF; cin = 1'b1; sub = 1'b0;

        // Reset state; in_valid held through reset must not be captured.
        step(); step();
        chk("rst_state", {62'b0, dbg_state}, 64'd0);
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_sum", sum, 64'd0);
        chk("rst_co", {63'b0, co}, 64'd0);
        rst = 1'b0; in_valid = 1'b0;
        step();
        chk("post_rst_in_ready", {63'b0, in_ready}, 64'd1);
        chk("post_rst_busy", {63'b0, busy}, 64'd0);

        // Carry out of slice 0 only, full ripple, and mixed-slice patterns.
        run_op("ffff_plus_1", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0,
               64'h0000_0000_0001_0000, 1'b0);
        run_op("ripple_all", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1);
        run_op("alt_slices", 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0,
               64'h0001_0000_0001_0000, 1'b0);
        run_op("compl_no_cin", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        run_op("max_max_cin", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b1);

        // Stall in DONE for 10 cycles with a new request pending: everything holds.
        a = 64'd3; b = 64'd4; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        step();
        a = 64'd100; b = 64'd200;
        step(); step(); step(); step();
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", {63'b0, out_valid}, 64'd1);
            chk("stall_sum", sum, 64'd7);
            chk("stall_co", {63'b0, co}, 64'd0);
            chk("stall_in_ready", {63'b0, in_ready}, 64'd0);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("stall_retire", {63'b0, out_valid}, 64'd0);
        chk("stall_idle_ready", {63'b0, in_ready}, 64'd1);
        chk("sum_held_after_retire", sum, 64'd7);
        step();
        chk("no_phantom_accept", {63'b0, busy}, 64'd0);

        // Back-to-back with in_valid and out_ready held high: accepts 6 edges apart.
        a = 64'h1234; b = 64'h0001; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        step();
        chk("b2b_accept1", {62'b0, dbg_state}, 64'd1);
        a = 64'h8000_0000_0000_0000; b = 64'h8000_0000_0000_0000;
        step(); step(); step();
        chk("b2b_early1", {63'b0, out_valid}, 64'd0);
        step();
        chk("b2b_valid1", {63'b0, out_valid}, 64'd1);
        chk("b2b_sum1", sum, 64'h1235);
        chk("b2b_co1", {63'b0, co}, 64'd0);
        step();
        chk("b2b_retire1", {63'b0, out_valid}, 64'd0);
        chk("b2b_ready_gap", {63'b0, in_ready}, 64'd1);
        step();
        chk("b2b_accept2", {63'b0, busy}, 64'd1);
        step(); step(); step();
        chk("b2b_early2", {63'b0, out_valid}, 64'd0);
        step();
        in_valid = 1'b0;
        chk("b2b_valid2", {63'b0, out_valid}, 64'd1);
        chk("b2b_sum2", sum, 64'd0);
        chk("b2b_co2", {63'b0, co}, 64'd1);
        step();
        out_ready = 1'b0;
        chk("b2b_retire2", {63'b0, out_valid}, 64'd0);

        // Reset two edges after accept abandons the operation.
        a = 64'h0000_0000_0000_FFFF; b = 64'h0000_0000_0000_FFFF; cin = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_valid", {63'b0, out_valid}, 64'd0);
        chk("abort_sum", sum, 64'd0);
        chk("abort_co", {63'b0, co}, 64'd0);
        chk("abort_in_ready", {63'b0, in_ready}, 64'd1);
        chk("abort_busy", {63'b0, busy}, 64'd0);
        for (int i = 0; i < 6; i++) step();
        chk("abort_no_result", {63'b0, out_valid}, 64'd0);

`ifdef ADDER_SUB_EN
        run_op("sub_5_7", 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        run_op("sub_7_5", 64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1);
        run_op("sub_ignores_cin", 64'd7, 64'd5, 1'b1, 1'b1, 64'd2, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
